n2_ifu_resp: RTL
================

N2_IFU_RESP -- requirements
Module: n2_ifu_resp

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 8, meaning number of instruction-queue slots, indexed by the 3-bit queue pointers.
REQ-002 SHALL have ports `clk` (in, 1, sole clock) and `resetn` (in, 1, asynchronous active-low reset).
REQ-003 SHALL have port `flush_i` (in, 1): redirect; drops all queued and in-flight instructions.
REQ-004 SHALL have port `instr_req_i` (in, 1): fetch request from the IFU.
REQ-005 SHALL have port `instr_req_2b_i` (in, 2): lane mask; 2'b01 is one word, 2'b11 is two words.
REQ-006 SHALL have port `instr_addr_i` (in, 32): fetch PC, word-aligned.
REQ-007 SHALL have port `instr_gnt_o` (out, 1): request accepted this cycle.
REQ-008 SHALL have port `iq_prefetch_ptr_i` (in, 3): IFU write pointer, sampled on grant.
REQ-009 SHALL have ports `mem_req_o` (out, 1) and `mem_addr_o` (out, 32, 8-byte aligned) toward instruction memory.
REQ-010 SHALL have port `mem_busy_i` (in, 1): memory cannot accept a request.
REQ-011 SHALL have ports `mem_rvalid_i` (in, 1) and `mem_rdata_i` (in, 64): in-order read responses.
REQ-012 SHALL have port `deq_num_i` (in, 2): number of instructions consumed by decode (0, 1 or 2).
REQ-013 SHALL have ports `instr0_v_o`/`instr1_v_o` (out, 1), `instr0_o`/`instr1_o` (out, 32) and `pc0_o`/`pc1_o` (out, 32).
REQ-014 SHALL have port `iq_rd_ptr_o` (out, 3): queue read pointer returned to the IFU.
REQ-015 SHALL have port `resp_err_o` (out, 1): sticky flag for an unexpected response.

Function
REQ-016 instr_gnt_o SHALL equal instr_req_i & ~mem_busy_i & ~flush_i & (outstanding<2), combinationally.
REQ-017 mem_req_o SHALL equal instr_gnt_o; mem_addr_o SHALL be {instr_addr_i[31:3],3'b000}.
REQ-018 On grant, SHALL push {slot=iq_prefetch_ptr_i, lanes, addr, epoch} into a 2-entry in-order tracker.
REQ-019 On mem_rvalid_i with a non-empty tracker, SHALL pop the head entry.
REQ-020 If the popped entry's epoch matches the current epoch, SHALL write the response into the queue:
  - lanes 2'b11: slot s gets rdata[31:0], slot s+1 gets rdata[63:32].
  - lanes 2'b01: slot s gets rdata[63:32] if addr[2] else rdata[31:0].
  - each written slot's valid bit is set and its PC stored (slot s+1 PC = addr+4).
REQ-021 Slot index arithmetic SHALL wrap modulo 8.
REQ-022 On mem_rvalid_i with an empty tracker, SHALL ignore the data and set resp_err_o (cleared only by reset).
REQ-023 Read side, combinational from registered state:
  - instr0_v_o = valid[rd].
  - instr1_v_o = instr0_v_o & valid[rd+1].
  - data and PC outputs come from slots rd and rd+1.
REQ-024 deq_num_i SHALL be clamped to the number of valid outputs; rd advances by the clamped count and the consumed valid bits are cleared next cycle.
REQ-025 Simultaneous write and dequeue of different slots SHALL both take effect; a slot SHALL never be written and dequeued in the same cycle.
REQ-026 On flush_i, the next cycle SHALL:
  - clear all valid bits;
  - set rd to iq_prefetch_ptr_i;
  - toggle the 1-bit epoch.
  Tracker entries are retained but carry the stale epoch, so their responses are popped and discarded.
REQ-027 A response arriving in the flush cycle SHALL be discarded.
REQ-028 Latency: a response in cycle t SHALL be visible on instr0_o in cycle t+1.

Reset
REQ-029 While resetn is low, the block SHALL drive:
  - tracker empty, epoch 0, all valid bits 0, rd 0;
  - resp_err_o 0, all instr*_v_o 0;
  - data and PC outputs 0 (queue contents zeroed).
REQ-030 Assertion mid-transaction SHALL drop outstanding requests; responses arriving after release with an empty tracker SHALL set resp_err_o.

Configuration
REQ-031 With macro N2_IQ_PC_EN defined, SHALL store a 32-bit PC per slot and drive pc0_o/pc1_o as specified.
REQ-032 Without N2_IQ_PC_EN, SHALL omit PC storage and tie pc0_o/pc1_o to 0; all other behaviour SHALL be unchanged.

Verification
REQ-033 Req addr 0x100, lanes 11, ptr 0; response 0xBBBB_BBBB_AAAA_AAAA -> next cycle instr0=0xAAAAAAAA/pc 0x100 and instr1=0xBBBBBBBB/pc 0x104, both valid.
REQ-034 Req addr 0x104, lanes 01, ptr 3 (rd=3) -> slot 3 = rdata[63:32], instr0_v=1, instr1_v=0; deq_num=2 -> rd=4.
REQ-035 Two grants in flight, mem_busy_i=0 -> third request sees instr_gnt_o=0 until the first rvalid.
REQ-036 Flush with 2 requests outstanding, iq_prefetch_ptr_i=6 -> rd=6, both later responses discarded, instr0_v stays 0.
REQ-037 Ptr 7, lanes 11 -> slots 7 and 0 written, outputs wrap correctly.
REQ-038 rvalid with no outstanding request -> resp_err_o=1 and sticky; resetn low clears it; build and repeat REQ-033 without N2_IQ_PC_EN -> pc0_o=pc1_o=0.

Source files
------------

// File: rtl/n2_ifu_resp.sv
// Instruction-fetch response unit: tracks up to two fetches, fills the instruction queue, serves decode.
// Optional per-slot PC storage is enabled with `define N2_IQ_PC_EN.
module n2_ifu_resp #(
  parameter int IQ_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush_i,
  input  logic        instr_req_i,
  input  logic [1:0]  instr_req_2b_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  input  logic [2:0]  iq_prefetch_ptr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_busy_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  input  logic [1:0]  deq_num_i,
  output logic        instr0_v_o,
  output logic        instr1_v_o,
  output logic [31:0] instr0_o,
  output logic [31:0] instr1_o,
  output logic [31:0] pc0_o,
  output logic [31:0] pc1_o,
  output logic [2:0]  iq_rd_ptr_o,
  output logic        resp_err_o
);

  logic [2:0]          trk_slot  [2];
  logic                trk_dual  [2];
  logic                trk_a2    [2];
  logic                trk_epoch [2];
  logic                trk_wr;
  logic                trk_rd;
  logic [1:0]          trk_cnt;

  logic                epoch;
  logic [2:0]          rd;
  logic [IQ_DEPTH-1:0] iq_valid;
  logic [IQ_DEPTH-1:0] valid_nxt;
  logic [31:0]         iq_instr [IQ_DEPTH];

  logic                pop;
  logic                wr_en;
  logic                wr_dual;
  logic [2:0]          wr_slot0;
  logic [2:0]          wr_slot1;
  logic [31:0]         wr_data0;
  logic [2:0]          rd1;
  logic [1:0]          deq_eff;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^instr_addr_i[1:0];

  assign instr_gnt_o = instr_req_i & ~mem_busy_i & ~flush_i & (trk_cnt < 2'd2);
  assign mem_req_o   = instr_gnt_o;
  assign mem_addr_o  = {instr_addr_i[31:3], 3'b000};

  // Stale-epoch or flush-cycle responses still pop the tracker but never reach the queue.
  assign pop      = mem_rvalid_i & (trk_cnt != 2'd0);
  assign wr_en    = pop & (trk_epoch[trk_rd] == epoch) & ~flush_i;
  assign wr_dual  = trk_dual[trk_rd];
  assign wr_slot0 = trk_slot[trk_rd];
  assign wr_slot1 = wr_slot0 + 3'd1;
  assign wr_data0 = (!wr_dual && trk_a2[trk_rd]) ? mem_rdata_i[63:32] : mem_rdata_i[31:0];

  assign rd1         = rd + 3'd1;
  assign instr0_v_o  = iq_valid[rd];
  assign instr1_v_o  = instr0_v_o & iq_valid[rd1];
  assign instr0_o    = iq_instr[rd];
  assign instr1_o    = iq_instr[rd1];
  assign iq_rd_ptr_o = rd;

  always_comb begin
    deq_eff = 2'd0;
    if (deq_num_i >= 2'd2 && instr1_v_o)
      deq_eff = 2'd2;
    else if (deq_num_i != 2'd0 && instr0_v_o)
      deq_eff = 2'd1;
  end

  always_comb begin
    valid_nxt = iq_valid;
    if (flush_i) begin
      valid_nxt = '0;
    end else begin
      if (deq_eff != 2'd0) valid_nxt[rd]  = 1'b0;
      if (deq_eff == 2'd2) valid_nxt[rd1] = 1'b0;
      if (wr_en) begin
        valid_nxt[wr_slot0] = 1'b1;
        if (wr_dual) valid_nxt[wr_slot1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trk_wr  <= 1'b0;
      trk_rd  <= 1'b0;
      trk_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        trk_slot[i]  <= 3'd0;
        trk_dual[i]  <= 1'b0;
        trk_a2[i]    <= 1'b0;
        trk_epoch[i] <= 1'b0;
      end
    end else begin
      if (instr_gnt_o) begin
        trk_slot[trk_wr]  <= iq_prefetch_ptr_i;
        trk_dual[trk_wr]  <= (instr_req_2b_i == 2'b11);
        trk_a2[trk_wr]    <= instr_addr_i[2];
        trk_epoch[trk_wr] <= epoch;
        trk_wr            <= ~trk_wr;
      end
      if (pop) trk_rd <= ~trk_rd;
      case ({instr_gnt_o, pop})
        2'b10:   trk_cnt <= trk_cnt + 2'd1;
        2'b01:   trk_cnt <= trk_cnt - 2'd1;
        default: trk_cnt <= trk_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epoch      <= 1'b0;
      rd         <= 3'd0;
      iq_valid   <= '0;
      resp_err_o <= 1'b0;
    end else begin
      epoch      <= epoch ^ flush_i;
      rd         <= flush_i ? iq_prefetch_ptr_i : rd + {1'b0, deq_eff};
      iq_valid   <= valid_nxt;
      resp_err_o <= resp_err_o | (mem_rvalid_i & (trk_cnt == 2'd0));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < IQ_DEPTH; i++) iq_instr[i] <= 32'd0;
    end else if (wr_en) begin
      iq_instr[wr_slot0] <= wr_data0;
      if (wr_dual) iq_instr[wr_slot1] <= mem_rdata_i[63:32];
    end
  end

`ifdef N2_IQ_PC_EN
  logic [31:0] trk_pc [2];
  logic [31:0] iq_pc  [IQ_DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trk_pc[0] <= 32'd0;
      trk_pc[1] <= 32'd0;
      for (int i = 0; i < IQ_DEPTH; i++) iq_pc[i] <= 32'd0;
    end else begin
      if (instr_gnt_o) trk_pc[trk_wr] <= instr_addr_i;
      if (wr_en) begin
        iq_pc[wr_slot0] <= trk_pc[trk_rd];
        if (wr_dual) iq_pc[wr_slot1] <= trk_pc[trk_rd] + 32'd4;
      end
    end
  end

  assign pc0_o = iq_pc[rd];
  assign pc1_o = iq_pc[rd1];
`else
  assign pc0_o = 32'd0;
  assign pc1_o = 32'd0;
`endif

endmodule
